// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state codes, funct3 size codes and request checks for dmem_ctrl
package dmem_pkg;

   localparam int MEM_ADDR_BITS = 17;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_READ  = 2'd1;
   localparam state_t ST_WRITE = 2'd2;
   localparam state_t ST_RESP  = 2'd3;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   function automatic logic size_legal(input logic we, input logic [2:0] size);
      if (we)
         return (size == SZ_B) || (size == SZ_H) || (size == SZ_W);
      return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) ||
             (size == SZ_BU) || (size == SZ_HU);
   endfunction

   function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lsb);
      case (size)
         SZ_H, SZ_HU: return lsb[0];
         SZ_W:        return lsb != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// rtl/dmem_lsu_align.sv - load sign/zero extension and sub-word store merge
// rd is the word read at the request address, so the addressed byte is always rd[7:0].
module dmem_lsu_align #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [2:0]            size,
   input  logic [DATA_WIDTH-1:0] rd,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic [DATA_WIDTH-1:0] store_data
);
   import dmem_pkg::*;

   always_comb begin
      load_data = rd;
      case (size)
         SZ_B:    load_data = {{(DATA_WIDTH-8){rd[7]}}, rd[7:0]};
         SZ_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, rd[7:0]};
         SZ_H:    load_data = {{(DATA_WIDTH-16){rd[15]}}, rd[15:0]};
         SZ_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, rd[15:0]};
         default: load_data = rd;
      endcase
   end

   always_comb begin
      store_data = wdata;
      case (size)
         SZ_B:    store_data = {rd[DATA_WIDTH-1:8], wdata[7:0]};
         SZ_H:    store_data = {rd[DATA_WIDTH-1:16], wdata[15:0]};
         default: store_data = wdata;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - two-port round-robin data memory controller with sub-word read-modify-write
module dmem_ctrl #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 32,
   parameter int MEM_ADDR_BITS = dmem_pkg::MEM_ADDR_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  p0_req,
   input  logic                  p0_we,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   input  logic [2:0]            p0_size,
   output logic                  p0_gnt,
   output logic                  p0_rvalid,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   output logic                  p0_err,
   input  logic                  p1_req,
   input  logic                  p1_we,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   input  logic [2:0]            p1_size,
   output logic                  p1_gnt,
   output logic                  p1_rvalid,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic                  p1_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);
   import dmem_pkg::*;

   state_t                state_q;
   logic                  last_grant_q;
   logic                  port_q;
   logic                  we_q;
   logic                  err_q;
   logic [2:0]            size_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rd_q;

   logic                  sel_p1;
   logic                  any_req;
   logic                  in_idle;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [2:0]            req_size;
   logic                  req_err;
   logic [DATA_WIDTH-1:0] load_data;
   logic [DATA_WIDTH-1:0] store_data;
   logic [DATA_WIDTH-1:0] resp_data;
   logic                  resp;

   // On a tie the port that was not granted last wins.
   assign sel_p1    = p1_req && (!p0_req || !last_grant_q);
   assign any_req   = p0_req || p1_req;
   assign in_idle   = (state_q == ST_IDLE) && !rst;
   assign p0_gnt    = in_idle && p0_req && !sel_p1;
   assign p1_gnt    = in_idle && sel_p1;

   assign req_we    = sel_p1 ? p1_we    : p0_we;
   assign req_addr  = sel_p1 ? p1_addr  : p0_addr;
   assign req_wdata = sel_p1 ? p1_wdata : p0_wdata;
   assign req_size  = sel_p1 ? p1_size  : p0_size;
   assign req_err   = (|(req_addr >> MEM_ADDR_BITS)) ||
                      !size_legal(req_we, req_size) ||
                      misaligned(req_size, req_addr[1:0]);

   dmem_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .size       (size_q),
      .rd         (rd_q),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_data (store_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         size_q       <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rd_q         <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any_req) begin
                  port_q       <= sel_p1;
                  last_grant_q <= sel_p1;
                  we_q         <= req_we;
                  err_q        <= req_err;
                  size_q       <= req_size;
                  addr_q       <= req_addr;
                  wdata_q      <= req_wdata;
                  if (req_err)
                     state_q <= ST_RESP;
                  else if (req_we && req_size == SZ_W)
                     state_q <= ST_WRITE;
                  else
                     state_q <= ST_READ;
               end
            end
            ST_READ: begin
               rd_q    <= mem_rdata;
               state_q <= we_q ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: state_q <= ST_RESP;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   assign resp      = (state_q == ST_RESP);
   assign resp_data = (err_q || we_q) ? '0 : load_data;

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      if (state_q == ST_READ) begin
         mem_addr = addr_q;
      end else if (state_q == ST_WRITE) begin
         mem_addr  = addr_q;
         mem_wdata = store_data;
         mem_we    = 1'b1;
      end
   end

   always_comb begin
      p0_rvalid = resp && !port_q;
      p1_rvalid = resp && port_q;
      p0_err    = p0_rvalid && err_q;
      p1_err    = p1_rvalid && err_q;
      p0_rdata  = p0_rvalid ? resp_data : '0;
      p1_rdata  = p1_rvalid ? resp_data : '0;
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed vector bench for dmem_ctrl with a byte-array memory model
module tb_dmem_ctrl;

   localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

   typedef struct {
      int          port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  size;
      logic        pre_en;
      logic [31:0] pre_addr;
      logic [31:0] pre_data;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_we;
      logic [31:0] chk_addr;
      logic [31:0] exp_mem;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
   logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
   logic [2:0]  p0_size = 0, p1_size = 0;
   logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
   logic [31:0] p0_rdata, p1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;

   logic [7:0]  mem [0:(1<<17)-1];
   int          we_cnt = 0;
   logic        pl_en = 0;
   logic [31:0] pl_addr = 0, pl_data = 0;

   int tests = 0;
   int fails = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   dmem_ctrl dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_size(p0_size),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_size(p1_size),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always_comb begin
      mem_rdata = '0;
      for (int i = 0; i < 4; i++)
         mem_rdata[8*i +: 8] = mem[17'(mem_addr + 32'(i))];
   end

   always @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++)
            mem[17'(mem_addr + 32'(i))] <= mem_wdata[8*i +: 8];
         we_cnt <= we_cnt + 1;
      end
      if (pl_en)
         for (int i = 0; i < 4; i++)
            mem[17'(pl_addr + 32'(i))] <= pl_data[8*i +: 8];
   end

   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [31:0] w;
      for (int i = 0; i < 4; i++)
         w[8*i +: 8] = mem[17'(a + 32'(i))];
      return w;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 0;
   endtask

   task automatic drive(input int p, input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] sz);
      if (p == 0) begin
         p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d; p0_size = sz;
      end else begin
         p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d; p1_size = sz;
      end
   endtask

   task automatic run_vec(input string name, input vec_t v);
      int n;
      int lat;
      int we0;
      logic g, rv, orv;
      if (v.pre_en) preload(v.pre_addr, v.pre_data);
      @(negedge clk);
      drive(v.port, 1, v.we, v.addr, v.wdata, v.size);
      #1;
      n = 0;
      g = (v.port == 0) ? p0_gnt : p1_gnt;
      while (!g && n < 20) begin
         @(negedge clk); #1; n++;
         g = (v.port == 0) ? p0_gnt : p1_gnt;
      end
      chk({name, "/gnt"}, 32'(g), 32'd1);
      chk({name, "/other_gnt"}, 32'((v.port == 0) ? p1_gnt : p0_gnt), 32'd0);
      we0 = we_cnt;
      @(negedge clk);
      drive(v.port, 0, 0, 0, 0, 0);
      #1;
      lat = 1;
      rv = (v.port == 0) ? p0_rvalid : p1_rvalid;
      while (!rv && lat < 10) begin
         @(negedge clk); #1; lat++;
         rv = (v.port == 0) ? p0_rvalid : p1_rvalid;
      end
      orv = (v.port == 0) ? (p1_rvalid | p1_err | (|p1_rdata)) : (p0_rvalid | p0_err | (|p0_rdata));
      chk({name, "/latency"}, 32'(lat), 32'(v.exp_lat));
      chk({name, "/rdata"}, (v.port == 0) ? p0_rdata : p1_rdata, v.exp_rdata);
      chk({name, "/err"}, 32'((v.port == 0) ? p0_err : p1_err), 32'(v.exp_err));
      chk({name, "/other_port_quiet"}, 32'(orv), 32'd0);
      chk({name, "/resp_mem_addr"}, mem_addr, 32'd0);
      chk({name, "/we_cycles"}, 32'(we_cnt - we0), 32'(v.exp_we));
      chk({name, "/mem_word"}, word_at(v.chk_addr), v.exp_mem);
   endtask

   initial begin
      int grants[$];
      int n;
      int we0;
      logic saw_rv;
      vec_t v;

      // Reset state with a live request present
      drive(0, 1, 0, 32'h10000, 0, W);
      drive(1, 1, 0, 32'h10000, 0, W);
      repeat (2) @(negedge clk);
      #1;
      chk("reset/p0_gnt", 32'(p0_gnt), 0);
      chk("reset/p1_gnt", 32'(p1_gnt), 0);
      chk("reset/rvalid", 32'({p0_rvalid, p1_rvalid, p0_err, p1_err}), 0);
      chk("reset/rdata", p0_rdata | p1_rdata, 0);
      chk("reset/mem", {mem_addr[30:0], mem_we} | mem_wdata, 0);

      // Continuous requests on both ports from reset release: p0 first, then alternate
      @(negedge clk);
      rst = 0;
      #1;
      n = 0;
      while (grants.size() < 4 && n < 40) begin
         if (p0_gnt && p1_gnt) chk("arb/both_gnt", 32'd1, 32'd0);
         if (p0_gnt) grants.push_back(0);
         if (p1_gnt) grants.push_back(1);
         @(negedge clk); #1; n++;
      end
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      chk("arb/grant_count", 32'(grants.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("arb/grant%0d", i), (i < grants.size()) ? 32'(grants[i]) : 32'hFFFF_FFFF, 32'(i % 2));
      repeat (4) @(negedge clk);

      //          port we addr         wdata        size pre pre_addr     pre_data     err exp_rdata  lat we chk_addr     exp_mem
      vecs.push_back('{0, 0, 32'h10000, 32'h0,        W,  1, 32'h10000, 32'h8899AABB, 0, 32'h8899AABB, 2, 0, 32'h10000, 32'h8899AABB});
      vecs.push_back('{0, 0, 32'h10001, 32'h0,        B,  1, 32'h10000, 32'h889980BB, 0, 32'hFFFFFF80, 2, 0, 32'h10000, 32'h889980BB});
      vecs.push_back('{1, 0, 32'h10001, 32'h0,        BU, 0, 32'h0,     32'h0,        0, 32'h00000080, 2, 0, 32'h10000, 32'h889980BB});
      vecs.push_back('{0, 0, 32'h10002, 32'h0,        H,  0, 32'h0,     32'h0,        0, 32'hFFFF8899, 2, 0, 32'h10000, 32'h889980BB});
      vecs.push_back('{1, 0, 32'h10002, 32'h0,        HU, 0, 32'h0,     32'h0,        0, 32'h00008899, 2, 0, 32'h10000, 32'h889980BB});
      vecs.push_back('{0, 1, 32'h10004, 32'hDEADBEEF, B,  1, 32'h10004, 32'h11223344, 0, 32'h0,        3, 1, 32'h10004, 32'h112233EF});
      vecs.push_back('{1, 1, 32'h10006, 32'hCAFE1234, H,  1, 32'h10008, 32'h0,        0, 32'h0,        3, 1, 32'h10004, 32'h123433EF});
      vecs.push_back('{0, 1, 32'h10008, 32'hA5A50F0F, W,  0, 32'h0,     32'h0,        0, 32'h0,        2, 1, 32'h10008, 32'hA5A50F0F});
      vecs.push_back('{1, 0, 32'h10008, 32'h0,        W,  0, 32'h0,     32'h0,        0, 32'hA5A50F0F, 2, 0, 32'h10008, 32'hA5A50F0F});
      vecs.push_back('{0, 1, 32'h10002, 32'h12345678, W,  0, 32'h0,     32'h0,        1, 32'h0,        1, 0, 32'h10000, 32'h889980BB});
      vecs.push_back('{0, 0, 32'h20000, 32'h0,        W,  0, 32'h0,     32'h0,        1, 32'h0,        1, 0, 32'h10000, 32'h889980BB});
      vecs.push_back('{1, 0, 32'h10003, 32'h0,        H,  0, 32'h0,     32'h0,        1, 32'h0,        1, 0, 32'h10000, 32'h889980BB});
      vecs.push_back('{0, 0, 32'h10001, 32'h0,        W,  0, 32'h0,     32'h0,        1, 32'h0,        1, 0, 32'h10000, 32'h889980BB});
      vecs.push_back('{1, 0, 32'h10000, 32'h0,     3'b011, 0, 32'h0,     32'h0,        1, 32'h0,        1, 0, 32'h10000, 32'h889980BB});
      vecs.push_back('{0, 1, 32'h10000, 32'h0,        BU, 0, 32'h0,     32'h0,        1, 32'h0,        1, 0, 32'h10000, 32'h889980BB});
      vecs.push_back('{0, 0, 32'h1FFFF, 32'h0,        B,  1, 32'h1FFFC, 32'h7F000000, 0, 32'h0000007F, 2, 0, 32'h1FFFC, 32'h7F000000});
      vecs.push_back('{1, 0, 32'h1FFFE, 32'h0,        HU, 0, 32'h0,     32'h0,        0, 32'h00007F00, 2, 0, 32'h1FFFC, 32'h7F000000});

      foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Reset asserted in the WRITE cycle of a byte store aborts it cleanly
      preload(32'h10004, 32'h11223344);
      @(negedge clk);
      drive(0, 1, 1, 32'h10004, 32'hDEADBEEF, B);
      #1;
      n = 0;
      while (!p0_gnt && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk("rstwr/gnt", 32'(p0_gnt), 1);
      we0 = we_cnt;
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      chk("rstwr/in_write", 32'(mem_we), 1);
      rst = 1;
      #1;
      chk("rstwr/we_drop", 32'(mem_we), 0);
      chk("rstwr/addr_drop", mem_addr, 0);
      @(negedge clk);
      rst = 0;
      saw_rv = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         saw_rv |= p0_rvalid | p1_rvalid;
      end
      chk("rstwr/no_rvalid", 32'(saw_rv), 0);
      chk("rstwr/no_write", 32'(we_cnt - we0), 0);
      chk("rstwr/mem_word", word_at(32'h10004), 32'h11223344);
      v = '{0, 0, 32'h10004, 32'h0, W, 0, 32'h0, 32'h0, 0, 32'h11223344, 2, 0, 32'h10004, 32'h11223344};
      run_vec("rstwr/after", v);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, the byte address width.
REQ-003 SHALL have parameter MEM_ADDR_BITS, default 17, giving a legal byte range of 0 to 2^17-1.
REQ-004 SHALL have one clock and an asynchronous active-high reset: clk input 1 rising-edge clock; rst input 1 async active-high reset.
REQ-005 SHALL have requester ports p0_* (CPU, index 0) and p1_* (aux/loader, index 1), each with the signals below.
- pN_req input 1: request pending.
- pN_we input 1: 1 = store, 0 = load.
- pN_addr input ADDR_WIDTH: byte address.
- pN_wdata input DATA_WIDTH: store data.
- pN_size input 3: funct3 code.
- pN_gnt output 1: request accepted this cycle.
- pN_rvalid output 1: one-cycle completion pulse.
- pN_rdata output DATA_WIDTH: load result, valid with rvalid.
- pN_err output 1: error flag, valid with rvalid.
REQ-006 SHALL have memory-side ports: mem_addr output ADDR_WIDTH; mem_wdata output DATA_WIDTH; mem_we output 1; mem_rdata input DATA_WIDTH. The memory side is a byte-addressed memory with combinational little-endian 4-byte read at mem_addr and a 4-byte write at the clk edge when mem_we is high.

Function
REQ-007 SHALL implement the states IDLE, READ, WRITE and RESP.
REQ-008 In IDLE, gnt SHALL be driven combinationally to exactly one requesting port. The request fields SHALL be latched at that edge.
REQ-009 Arbitration SHALL be round-robin. On a tie, the port not granted last wins. last_grant SHALL reset to 1, so port 0 wins the first tie.
REQ-010 A request SHALL be an error if any of the following holds:
- pN_addr[ADDR_WIDTH-1:MEM_ADDR_BITS] != 0;
- LH/LHU/SH at an odd address;
- LW/SW at an address with addr[1:0] != 0;
- the size code is illegal: loads allow 000, 001, 010, 100, 101; stores allow 000, 001, 010.
REQ-011 An error request SHALL go IDLE -> RESP, then pulse rvalid with err=1 and rdata=0. mem_we SHALL never be asserted for an error request.
REQ-012 A load SHALL follow IDLE(gnt, cycle N) -> READ(N+1, mem_addr=addr, result captured) -> RESP(N+2, rvalid) -> IDLE.
REQ-013 Load extension SHALL be: LB sign-extend [7:0]; LBU zero-extend [7:0]; LH sign-extend [15:0]; LHU zero-extend [15:0]; LW pass through.
REQ-014 A word store SHALL follow IDLE(N) -> WRITE(N+1, mem_we=1, mem_wdata=wdata) -> RESP(N+2) -> IDLE.
REQ-015 A sub-word store SHALL be a read-modify-write: IDLE(N) -> READ(N+1, capture mem_rdata) -> WRITE(N+2) -> RESP(N+3).
- SB writes {rd[31:8], wdata[7:0]}.
- SH writes {rd[31:16], wdata[15:0]}.
REQ-016 mem_we SHALL be high only in WRITE. mem_addr and mem_wdata SHALL be 0 in IDLE and RESP.
REQ-017 gnt SHALL never be asserted outside IDLE. Requests arriving in READ/WRITE/RESP SHALL wait, and the requester SHALL hold req until gnt.
REQ-018 rvalid SHALL go only to the latched port. rdata SHALL be 0 for stores. Outputs of the non-served port SHALL stay 0.

Reset
REQ-019 While rst is high, the block SHALL force state to IDLE, last_grant to 1, all gnt/rvalid/err/rdata to 0, and mem_we/mem_addr/mem_wdata to 0, asynchronously.
REQ-020 Reset asserted during READ or WRITE SHALL abort the access, with no write and no rvalid. Behaviour after release is as from power-up.

Structure
REQ-021 Package dmem_pkg SHALL hold the state enum, the funct3 size constants (SZ_B=000, SZ_H=001, SZ_W=010, SZ_BU=100, SZ_HU=101) and MEM_ADDR_BITS.
REQ-022 Load extension and store merge SHALL live in one combinational sub-module, dmem_lsu_align, instantiated once.

Verification
REQ-023 LW test: preload word 0x8899AABB at address 0x10000; p0 issues LW at 0x10000 -> gnt at N, p0_rvalid at N+2, rdata=0x8899AABB, err=0.
REQ-024 LB/LBU test: byte 0x80 at 0x10001 -> LB returns 0xFFFFFF80 and LBU returns 0x00000080.
REQ-025 SB test: word 0x11223344 at 0x10004; SB wdata 0xDEADBEEF at 0x10004 -> mem_we exactly one cycle at N+2, memory word becomes 0x112233EF, rvalid at N+3.
REQ-026 Arbitration test: p0 and p1 request continuously from reset -> grants alternate p0, p1, p0, p1.
REQ-027 Error test: SW at 0x10002 -> rvalid+err at N+1, mem_we never high, memory unchanged. LW at 0x00020000 -> err.
REQ-028 Reset test: rst asserted during the WRITE of an SB -> mem_we drops immediately, the target word is unchanged, no rvalid, and the next request is granted normally.
